// File: rtl/phx_tlb_lookup_ctrl.sv
// Lookup/refill controller for a 64-entry direct-mapped TLB RAM.
// Translates 4 KB pages, checks access rights, refills via a page-table walker and flushes the RAM.
module phx_tlb_lookup_ctrl #(
  parameter int WID = 160
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           flush,
  input  logic           req_valid,
  output logic           req_ready,
  input  logic [31:0]    req_vadr,
  input  logic [7:0]     req_asid,
  input  logic           req_we,
  output logic           resp_valid,
  output logic [31:0]    resp_padr,
  output logic           resp_prot_fault,
  output logic           resp_walk_fault,
  output logic           walk_req,
  output logic [31:0]    walk_vadr,
  output logic [7:0]     walk_asid,
  input  logic           walk_ack,
  input  logic [19:0]    walk_ppn,
  input  logic [2:0]     walk_rwx,
  input  logic           walk_fault,
  output logic           tlb_wr,
  output logic [5:0]     tlb_wa,
  output logic [WID-1:0] tlb_wdat,
  output logic [5:0]     tlb_ra,
  input  logic [WID-1:0] tlb_rdat
);

  localparam int ENT_W = 46;

  typedef enum logic [2:0] {
    ST_FLUSH,
    ST_IDLE,
    ST_LOOKUP,
    ST_WALK,
    ST_FILL
  } state_t;

  // Packed MSB-first, so this matches the RAM entry layout bit for bit.
  typedef struct packed {
    logic [19:0] ppn;
    logic [13:0] tag;
    logic [7:0]  asid;
    logic [2:0]  rwx;
    logic        v;
  } entry_t;

  state_t      state;
  state_t      state_nx;
  logic [5:0]  flush_cnt;
  logic        flush_pend;
  logic [31:0] vadr_q;
  logic [7:0]  asid_q;
  logic        we_q;
  entry_t      ent_q;
  logic [19:0] ppn_q;
  logic [2:0]  rwx_q;
  entry_t      fill_ent;
  logic        hit;
  logic        rv_nx;
  logic [31:0] padr_nx;
  logic        pf_nx;
  logic        wf_nx;

  function automatic logic prot_fault(input logic we, input logic [2:0] rwx);
    return we ? !rwx[1] : !rwx[0];
  endfunction

  assign tlb_ra   = req_vadr[17:12];
  assign hit      = ent_q.v && (ent_q.asid == asid_q) && (ent_q.tag == vadr_q[31:18]);
  assign fill_ent = '{ppn: ppn_q, tag: vadr_q[31:18], asid: asid_q, rwx: rwx_q, v: 1'b1};

  // Entry bits above the defined layout are never interpreted.
  if (WID > ENT_W) begin : g_unused
    logic unused_rdat;
    assign unused_rdat = ^tlb_rdat[WID-1:ENT_W];
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) state <= ST_FLUSH;
    else     state <= state_nx;
  end

  always_comb begin
    // NOTE: every combinational output gets a default first, so no path can infer a latch.
    state_nx  = state;
    req_ready = 1'b0;
    walk_req  = 1'b0;
    walk_vadr = '0;
    walk_asid = '0;
    tlb_wr    = 1'b0;
    tlb_wa    = '0;
    tlb_wdat  = '0;
    rv_nx     = 1'b0;
    padr_nx   = '0;
    pf_nx     = 1'b0;
    wf_nx     = 1'b0;

    case (state)
      ST_FLUSH: begin
        tlb_wr = 1'b1;
        tlb_wa = flush_cnt;
        if (flush_cnt == 6'd63) state_nx = ST_IDLE;
      end
      ST_IDLE: begin
        if (flush || flush_pend) begin
          state_nx = ST_FLUSH;
        end else begin
          req_ready = 1'b1;
          if (req_valid) state_nx = ST_LOOKUP;
        end
      end
      ST_LOOKUP: begin
        if (hit) begin
          rv_nx    = 1'b1;
          padr_nx  = {ent_q.ppn, vadr_q[11:0]};
          pf_nx    = prot_fault(we_q, ent_q.rwx);
          state_nx = ST_IDLE;
        end else begin
          state_nx = ST_WALK;
        end
      end
      ST_WALK: begin
        walk_req  = 1'b1;
        walk_vadr = vadr_q;
        walk_asid = asid_q;
        if (walk_ack) begin
          if (walk_fault) begin
            rv_nx    = 1'b1;
            wf_nx    = 1'b1;
            state_nx = ST_IDLE;
          end else begin
            state_nx = ST_FILL;
          end
        end
      end
      ST_FILL: begin
        tlb_wr               = 1'b1;
        tlb_wa               = vadr_q[17:12];
        tlb_wdat[ENT_W-1:0]  = fill_ent;
        rv_nx                = 1'b1;
        padr_nx              = {ppn_q, vadr_q[11:0]};
        pf_nx                = prot_fault(we_q, rwx_q);
        state_nx             = ST_IDLE;
      end
      default: state_nx = ST_FLUSH;
    endcase

    // Reset silences the combinational outputs immediately, aborting any walk in progress.
    if (rst) begin
      req_ready = 1'b0;
      walk_req  = 1'b0;
      walk_vadr = '0;
      walk_asid = '0;
      tlb_wr    = 1'b0;
      tlb_wa    = '0;
      tlb_wdat  = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      flush_cnt       <= '0;
      flush_pend      <= 1'b0;
      vadr_q          <= '0;
      asid_q          <= '0;
      we_q            <= 1'b0;
      ent_q           <= '0;
      ppn_q           <= '0;
      rwx_q           <= '0;
      resp_valid      <= 1'b0;
      resp_padr       <= '0;
      resp_prot_fault <= 1'b0;
      resp_walk_fault <= 1'b0;
    end else begin
      flush_cnt <= (state == ST_FLUSH) ? flush_cnt + 6'd1 : 6'd0;

      // A flush seen mid-request waits for the response; repeated pulses collapse into one.
      if (state == ST_IDLE)
        flush_pend <= 1'b0;
      else if (flush && (state == ST_LOOKUP || state == ST_WALK || state == ST_FILL))
        flush_pend <= 1'b1;

      if (req_valid && req_ready) begin
        vadr_q <= req_vadr;
        asid_q <= req_asid;
        we_q   <= req_we;
        ent_q  <= entry_t'(tlb_rdat[ENT_W-1:0]);
      end

      if (state == ST_WALK && walk_ack && !walk_fault) begin
        ppn_q <= walk_ppn;
        rwx_q <= walk_rwx;
      end

      resp_valid      <= rv_nx;
      resp_padr       <= padr_nx;
      resp_prot_fault <= pf_nx;
      resp_walk_fault <= wf_nx;
    end
  end

endmodule

// File: tb/tb_phx_tlb_lookup_ctrl.sv
// Self-checking bench for phx_tlb_lookup_ctrl: directed scenarios plus randomized traffic
// checked against a per-index model of TLB contents and a simple RAM model.
module tb_phx_tlb_lookup_ctrl;
  localparam int WID = 160;

  logic           clk;
  logic           rst;
  logic           flush;
  logic           req_valid;
  logic           req_ready;
  logic [31:0]    req_vadr;
  logic [7:0]     req_asid;
  logic           req_we;
  logic           resp_valid;
  logic [31:0]    resp_padr;
  logic           resp_prot_fault;
  logic           resp_walk_fault;
  logic           walk_req;
  logic [31:0]    walk_vadr;
  logic [7:0]     walk_asid;
  logic           walk_ack;
  logic [19:0]    walk_ppn;
  logic [2:0]     walk_rwx;
  logic           walk_fault;
  logic           tlb_wr;
  logic [5:0]     tlb_wa;
  logic [WID-1:0] tlb_wdat;
  logic [5:0]     tlb_ra;
  logic [WID-1:0] tlb_rdat;

  phx_tlb_lookup_ctrl #(.WID(WID)) dut (
    .clk(clk), .rst(rst), .flush(flush),
    .req_valid(req_valid), .req_ready(req_ready), .req_vadr(req_vadr),
    .req_asid(req_asid), .req_we(req_we),
    .resp_valid(resp_valid), .resp_padr(resp_padr),
    .resp_prot_fault(resp_prot_fault), .resp_walk_fault(resp_walk_fault),
    .walk_req(walk_req), .walk_vadr(walk_vadr), .walk_asid(walk_asid),
    .walk_ack(walk_ack), .walk_ppn(walk_ppn), .walk_rwx(walk_rwx), .walk_fault(walk_fault),
    .tlb_wr(tlb_wr), .tlb_wa(tlb_wa), .tlb_wdat(tlb_wdat),
    .tlb_ra(tlb_ra), .tlb_rdat(tlb_rdat)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // TLB RAM: synchronous write, asynchronous read.
  logic [WID-1:0] ram [64];
  always @(posedge clk) if (tlb_wr) ram[tlb_wa] <= tlb_wdat;
  assign tlb_rdat = ram[tlb_ra];

  // Reference view of what each TLB slot should hold.
  logic        m_v    [64];
  logic [7:0]  m_asid [64];
  logic [13:0] m_tag  [64];
  logic [19:0] m_ppn  [64];
  logic [2:0]  m_rwx  [64];

  int n_checks  = 0;
  int n_fail    = 0;
  int n_flush   = 0;
  int n_fill    = 0;
  int exp_resp  = 0;
  int wr_seen   = 0;
  int resp_seen = 0;

  task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
    end
  endtask

  always @(posedge clk) begin
    if (tlb_wr === 1'b1) wr_seen++;
    if (resp_valid === 1'b1) resp_seen++;
    else if (resp_valid === 1'b0 && rst === 1'b0)
      check("resp_idle_zero", {30'd0, resp_padr, resp_prot_fault, resp_walk_fault}, 64'd0);
  end

  // Entered at the negedge where the first flush write should be visible.
  task automatic expect_flush();
    for (int i = 0; i < 64; i++) begin
      #1;
      check("flush_wr", tlb_wr, 1);
      check("flush_wa", tlb_wa, i);
      check("flush_wdat", |tlb_wdat, 0);
      check("flush_ready", req_ready, 0);
      check("flush_no_resp", resp_valid, 0);
      check("flush_no_walk", walk_req, 0);
      if (i == 63) req_valid = 1'b0;
      @(negedge clk);
    end
    #1;
    check("flush_done_wr", tlb_wr, 0);
    check("flush_done_ready", req_ready, 1);
    for (int i = 0; i < 64; i++) m_v[i] = 1'b0;
    n_flush++;
  endtask

  task automatic idle_flush();
    @(negedge clk);
    flush = 1'b1;
    #1 check("flush_blocks_ready", req_ready, 0);
    @(negedge clk);
    flush = 1'b0;
    expect_flush();
  endtask

  // One translation; walker inputs are used only if the model predicts a miss.
  task automatic do_req(input logic [31:0] va, input logic [7:0] asid, input logic we,
                        input logic [19:0] ppn, input logic [2:0] rwx, input logic fault,
                        input int delay, input logic flush_mid,
                        output logic walked_o, output logic [31:0] padr_o,
                        output logic [5:0] wa_o, output logic prot_o);
    logic [5:0]  idx;
    logic [13:0] tg;
    logic        exp_hit;
    logic        e_prot;
    int          n;
    idx      = va[17:12];
    tg       = va[31:18];
    exp_hit  = m_v[idx] && m_asid[idx] == asid && m_tag[idx] == tg;
    walked_o = 1'b0;
    padr_o   = '0;
    wa_o     = '0;
    prot_o   = 1'b0;

    req_valid = 1'b1;
    req_vadr  = va;
    req_asid  = asid;
    req_we    = we;
    n = 0;
    #1;
    while (req_ready !== 1'b1) begin
      if (n == 100) begin
        check("accept_timeout", 0, 1);
        req_valid = 1'b0;
        return;
      end
      @(negedge clk); #1;
      n++;
    end
    @(negedge clk);
    req_valid = 1'b0;
    req_vadr  = $urandom;
    req_asid  = 8'($urandom);
    req_we    = ~we;
    #1;
    check("lookup_no_resp", resp_valid, 0);
    check("lookup_no_walk", walk_req, 0);
    @(negedge clk);

    if (exp_hit) begin
      e_prot = we ? !m_rwx[idx][1] : !m_rwx[idx][0];
      #1;
      walked_o = walk_req;
      padr_o   = resp_padr;
      prot_o   = resp_prot_fault;
      check("hit_valid", resp_valid, 1);
      check("hit_padr", resp_padr, {m_ppn[idx], va[11:0]});
      check("hit_prot", resp_prot_fault, e_prot);
      check("hit_wfault", resp_walk_fault, 0);
      check("hit_no_walk", walk_req, 0);
      exp_resp++;
    end else begin
      e_prot = we ? !rwx[1] : !rwx[0];
      if (flush_mid) flush = 1'b1;
      if (delay == 0) begin
        walk_ack = 1'b1; walk_ppn = ppn; walk_rwx = rwx; walk_fault = fault;
      end
      #1;
      walked_o = walk_req;
      check("walk_req", walk_req, 1);
      check("walk_vadr", walk_vadr, va);
      check("walk_asid", walk_asid, asid);
      check("walk_no_resp", resp_valid, 0);
      for (int d = 0; d < delay; d++) begin
        @(negedge clk);
        flush = 1'b0;
        if (d == delay - 1) begin
          walk_ack = 1'b1; walk_ppn = ppn; walk_rwx = rwx; walk_fault = fault;
        end
        #1;
        check("walk_hold", walk_req, 1);
        check("walk_hold_vadr", walk_vadr, va);
        check("walk_hold_asid", walk_asid, asid);
      end
      @(negedge clk);
      flush      = 1'b0;
      walk_ack   = 1'b0;
      walk_ppn   = 20'($urandom);
      walk_rwx   = 3'($urandom);
      walk_fault = 1'($urandom);
      #1;
      check("walk_drop", walk_req, 0);
      if (fault) begin
        padr_o = resp_padr;
        prot_o = resp_prot_fault;
        check("wf_valid", resp_valid, 1);
        check("wf_flag", resp_walk_fault, 1);
        check("wf_padr", resp_padr, 0);
        check("wf_prot", resp_prot_fault, 0);
        check("wf_no_write", tlb_wr, 0);
        exp_resp++;
      end else begin
        wa_o = tlb_wa;
        check("fill_wr", tlb_wr, 1);
        check("fill_wa", tlb_wa, idx);
        check("fill_wdat", tlb_wdat[45:0], {ppn, tg, asid, rwx, 1'b1});
        check("fill_wdat_hi", |tlb_wdat[WID-1:46], 0);
        check("fill_no_resp", resp_valid, 0);
        m_v[idx] = 1'b1; m_asid[idx] = asid; m_tag[idx] = tg;
        m_ppn[idx] = ppn; m_rwx[idx] = rwx;
        n_fill++;
        @(negedge clk); #1;
        padr_o = resp_padr;
        prot_o = resp_prot_fault;
        check("miss_valid", resp_valid, 1);
        check("miss_padr", resp_padr, {ppn, va[11:0]});
        check("miss_prot", resp_prot_fault, e_prot);
        check("miss_wfault", resp_walk_fault, 0);
        check("miss_after_fill_wr", tlb_wr, 0);
        exp_resp++;
      end
    end

    if (flush_mid && !exp_hit) begin
      check("pend_blocks_ready", req_ready, 0);
      @(negedge clk);
      expect_flush();
    end else begin
      @(negedge clk);
    end
  endtask

  logic [19:0] pool [8];
  logic        w;
  logic [31:0] p;
  logic [5:0]  wa;
  logic        pf;

  initial begin
    #500_000;
    $display("FAIL global_timeout: got no finish expected finish");
    $fatal(1);
  end

  initial begin
    rst = 1'b1; flush = 1'b0;
    req_valid = 1'b1; req_vadr = 32'h1234_5678; req_asid = 8'd3; req_we = 1'b0;
    walk_ack = 1'b0; walk_ppn = '0; walk_rwx = '0; walk_fault = 1'b0;
    for (int i = 0; i < 64; i++) m_v[i] = 1'b0;

    // Reset for two cycles with a request already pending.
    @(negedge clk);
    @(negedge clk);
    #1;
    check("rst_ready", req_ready, 0);
    check("rst_resp", resp_valid, 0);
    check("rst_walk", walk_req, 0);
    check("rst_wr", tlb_wr, 0);
    check("rst_wdat", |tlb_wdat, 0);
    rst = 1'b0;
    expect_flush();

    // Cold miss, then hit after fill.
    @(negedge clk);
    do_req(32'h1234_5678, 8'd3, 1'b0, 20'hABCDE, 3'b011, 1'b0, 1, 1'b0, w, p, wa, pf);
    check("cold_walked", w, 1);
    check("cold_wa", wa, 6'h05);
    check("cold_padr", p, 32'hABCDE678);
    check("cold_prot", pf, 0);
    do_req(32'h1234_5678, 8'd3, 1'b0, 20'h0, 3'b0, 1'b0, 0, 1'b0, w, p, wa, pf);
    check("hit_walked", w, 0);
    check("hit_padr_const", p, 32'hABCDE678);

    // ASID mismatch and tag mismatch on the same index.
    do_req(32'h1234_5678, 8'd4, 1'b0, 20'h11111, 3'b111, 1'b0, 0, 1'b0, w, p, wa, pf);
    check("asid_miss_walked", w, 1);
    do_req(32'h5234_5678, 8'd3, 1'b0, 20'h12121, 3'b111, 1'b0, 3, 1'b0, w, p, wa, pf);
    check("tag_miss_walked", w, 1);

    // Protection: read-only page.
    do_req(32'h0000_3ABC, 8'd5, 1'b1, 20'h22222, 3'b001, 1'b0, 2, 1'b0, w, p, wa, pf);
    check("ro_write_prot", pf, 1);
    check("ro_write_padr", p, 32'h22222ABC);
    do_req(32'h0000_3ABC, 8'd5, 1'b0, 20'h0, 3'b0, 1'b0, 0, 1'b0, w, p, wa, pf);
    check("ro_read_walked", w, 0);
    check("ro_read_prot", pf, 0);

    // Walk fault, then a repeat walks again.
    do_req(32'h0007_7123, 8'd9, 1'b0, 20'h55555, 3'b111, 1'b1, 1, 1'b0, w, p, wa, pf);
    check("wf_padr_const", p, 32'h0);
    do_req(32'h0007_7123, 8'd9, 1'b0, 20'h66666, 3'b111, 1'b0, 0, 1'b0, w, p, wa, pf);
    check("wf_repeat_walked", w, 1);
    check("wf_repeat_padr", p, 32'h66666123);

    // Flush pulsed mid-walk: response first, then the flush, then the old hit misses.
    do_req(32'h00AB_C456, 8'd1, 1'b0, 20'h33333, 3'b101, 1'b0, 0, 1'b0, w, p, wa, pf);
    do_req(32'h0100_1000, 8'd2, 1'b0, 20'h44444, 3'b111, 1'b0, 2, 1'b1, w, p, wa, pf);
    check("fmid_padr", p, 32'h44444000);
    do_req(32'h00AB_C456, 8'd1, 1'b0, 20'h77777, 3'b101, 1'b0, 0, 1'b0, w, p, wa, pf);
    check("post_flush_walked", w, 1);

    // Reset during a walk; a late ack during reset is ignored.
    @(negedge clk);
    req_valid = 1'b1; req_vadr = 32'h0F0F_0ABC; req_asid = 8'd7; req_we = 1'b0;
    #1 check("rstwalk_accept", req_ready, 1);
    @(negedge clk);
    req_valid = 1'b0;
    @(negedge clk);
    #1 check("rstwalk_req", walk_req, 1);
    @(negedge clk);
    rst = 1'b1; walk_ack = 1'b1; walk_ppn = 20'h99999; walk_rwx = 3'b111; walk_fault = 1'b0;
    @(negedge clk);
    walk_ack = 1'b0;
    #1 check("rst_drops_walk", walk_req, 0);
    @(negedge clk);
    rst = 1'b0;
    expect_flush();

    // Randomized traffic over a small page pool so hits, aliases and misses all occur.
    pool[0] = 20'h12345; pool[1] = 20'h52345; pool[2] = 20'h00003; pool[3] = 20'h40003;
    pool[4] = 20'h0ABCD; pool[5] = 20'h00077; pool[6] = 20'hFFFFF; pool[7] = 20'h00000;
    @(negedge clk);
    for (int t = 0; t < 200; t++) begin
      logic [31:0] va;
      if ($urandom_range(0, 24) == 0) idle_flush();
      va = {pool[$urandom_range(0, 7)], 12'($urandom)};
      do_req(va, 8'($urandom_range(1, 3)), 1'($urandom), 20'($urandom), 3'($urandom),
             $urandom_range(0, 7) == 0, $urandom_range(0, 3), $urandom_range(0, 19) == 0,
             w, p, wa, pf);
    end

    repeat (2) @(negedge clk);
    check("tlb_wr_total", wr_seen, 64 * n_flush + n_fill);
    check("resp_total", resp_seen, exp_resp);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
